// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM port between fetch and data requesters; define ARB_RR_EN for round-robin ties (default: DM wins ties)
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic [3:0]  dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        sram_cs,
    output logic        sram_oe,
    output logic [3:0]  sram_web,
    output logic [13:0] sram_a,
    output logic [31:0] sram_di,
    input  logic [31:0] sram_do
);
    typedef enum logic [1:0] {IDLE, ACC_IF, ACC_DM} state_t;
    state_t      state_q, state_d;
    logic [13:0] addr_q, addr_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic        dm_valid_q, dm_valid_d;
    logic        if_el, dm_el, pick_dm, acc, wr, unused_addr;
`ifdef ARB_RR_EN
    logic        last_q, last_d;
`endif
    assign unused_addr = ^{if_addr[31:16], if_addr[1:0], dm_addr[31:16], dm_addr[1:0]};
    assign if_el = if_req & ~if_valid_q;
    assign dm_el = dm_req & ~dm_valid_q;
`ifdef ARB_RR_EN
    assign pick_dm = dm_el & (~if_el | ~last_q);
`else
    assign pick_dm = dm_el;
`endif
    assign acc       = (state_q != IDLE) & ~rst;
    assign wr        = acc & (state_q == ACC_DM) & (|we_q);
    assign sram_cs   = acc;
    assign sram_oe   = acc & ~wr;
    assign sram_web  = wr ? ~we_q : 4'hF;
    assign sram_a    = acc ? addr_q : 14'h0;
    assign sram_di   = wr ? wdata_q : 32'h0;
    assign stall_if  = if_el;
    assign stall_mem = dm_el;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
`ifdef ARB_RR_EN
        last_d     = last_q;
`endif
        unique case (state_q)
            IDLE: if (if_el | dm_el) begin
                state_d = pick_dm ? ACC_DM : ACC_IF;
                addr_d  = pick_dm ? dm_addr[15:2] : if_addr[15:2];
                we_d    = pick_dm ? dm_we : 4'h0;
                wdata_d = pick_dm ? dm_wdata : 32'h0;
`ifdef ARB_RR_EN
                last_d  = pick_dm;
`endif
            end
            ACC_IF: begin
                state_d    = IDLE;
                if_valid_d = 1'b1;
                if_rdata_d = sram_do;
            end
            ACC_DM: begin
                state_d    = IDLE;
                dm_valid_d = 1'b1;
                dm_rdata_d = (|we_q) ? dm_rdata_q : sram_do;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 14'h0;
            we_q       <= 4'h0;
            wdata_q    <= 32'h0;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
`ifdef ARB_RR_EN
            last_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
`ifdef ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end
endmodule
